// File: rtl/param_stack.sv
// Parametrised LIFO for path/backtrack storage with peek, replace-top and error strobes.
// Optional high-water mark tracking when STACK_WATERMARK_EN is defined.
module param_stack #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d_in,
`ifdef STACK_WATERMARK_EN
  input  logic             clr_wm,
  output logic [CW-1:0]    max_count,
`endif
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_dvalid;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic             w_pop_ok;
  logic             w_wr_en;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_wr_idx;
  logic [CW-1:0]    w_count_nxt;

  // Refusal rules keep the count inside 0..DEPTH, so it can never wrap.
  function automatic logic [CW-1:0] f_count_nxt(
    input logic [CW-1:0] cnt,
    input logic          psh,
    input logic          pp,
    input logic          is_empty,
    input logic          is_full
  );
    if (pp && !is_empty)
      return psh ? cnt : cnt - ONE;
    if (psh && !is_full)
      return cnt + ONE;
    return cnt;
  endfunction

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL);
  assign w_pop_ok    = pop && !w_empty;
  assign w_top_idx   = w_empty ? '0 : AW'(r_count - ONE);
  // Replace-top writes over the current top; otherwise write the next free slot.
  assign w_wr_idx    = w_pop_ok ? w_top_idx : AW'(r_count);
  assign w_wr_en     = !rst && !init && push && (w_pop_ok || !w_full);
  assign w_count_nxt = f_count_nxt(r_count, push, pop, w_empty, w_full);

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[w_wr_idx] <= d_in;
  end

  always_ff @(posedge clk) begin
    if (rst || init) begin
      r_count  <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_dvalid <= w_pop_ok;
      r_ovf    <= push && !pop && w_full;
      r_unf    <= pop && w_empty;
      if (w_pop_ok)
        r_dout <= r_mem[w_top_idx];
    end
  end

`ifdef STACK_WATERMARK_EN
  logic [CW-1:0] r_max_count;

  always_ff @(posedge clk) begin
    if (rst || init)
      r_max_count <= '0;
    else if (clr_wm)
      r_max_count <= w_count_nxt;
    else if (w_count_nxt > r_max_count)
      r_max_count <= w_count_nxt;
  end

  assign max_count = r_max_count;
`endif

  assign d_out   = r_dout;
  assign d_valid = r_dvalid;
  assign count   = r_count;
  assign empty   = w_empty;
  assign full    = w_full;
  assign ovf     = r_ovf;
  assign unf     = r_unf;
  assign top     = w_empty ? '0 : r_mem[w_top_idx];

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack: directed scenarios plus random push/pop/init traffic
// checked against a queue-based LIFO model; a DEPTH=5 instance covers non-power-of-two fill.
module tb_param_stack;
  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int CW5   = $clog2(5 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b0, init = 1'b0, push = 1'b0, pop = 1'b0;
  logic [WIDTH-1:0] d_in = '0;
  logic [WIDTH-1:0] d_out, top;
  logic             d_valid, empty, full, ovf, unf;
  logic [CW-1:0]    count;
`ifdef STACK_WATERMARK_EN
  logic             clr_wm = 1'b0;
  logic [CW-1:0]    max_count;
  logic             p5_clr_wm = 1'b0;
  logic [CW5-1:0]   p5_max_count;
`endif

  logic             p5_rst = 1'b0, p5_init = 1'b0, p5_push = 1'b0, p5_pop = 1'b0;
  logic [WIDTH-1:0] p5_din = '0;
  logic [WIDTH-1:0] p5_dout, p5_top;
  logic             p5_dvalid, p5_empty, p5_full, p5_ovf, p5_unf;
  logic [CW5-1:0]   p5_count;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .init(init), .push(push), .pop(pop), .d_in(d_in),
`ifdef STACK_WATERMARK_EN
    .clr_wm(clr_wm), .max_count(max_count),
`endif
    .d_out(d_out), .d_valid(d_valid), .top(top), .count(count),
    .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  param_stack #(.WIDTH(WIDTH), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst(p5_rst), .init(p5_init), .push(p5_push), .pop(p5_pop), .d_in(p5_din),
`ifdef STACK_WATERMARK_EN
    .clr_wm(p5_clr_wm), .max_count(p5_max_count),
`endif
    .d_out(p5_dout), .d_valid(p5_dvalid), .top(p5_top), .count(p5_count),
    .empty(p5_empty), .full(p5_full), .ovf(p5_ovf), .unf(p5_unf)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a queue whose back is the top of stack.
  int q[$];
  int m_dout = 0;
  int m_max  = 0;
  bit m_dv = 0, m_ovf = 0, m_unf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},   32'(count),   32'(q.size()));
    chk({tag, ".top"},     32'(top),     (q.size() != 0) ? 32'(q[$]) : 32'd0);
    chk({tag, ".empty"},   32'(empty),   32'(q.size() == 0));
    chk({tag, ".full"},    32'(full),    32'(q.size() == DEPTH));
    chk({tag, ".d_out"},   32'(d_out),   32'(m_dout));
    chk({tag, ".d_valid"}, 32'(d_valid), 32'(m_dv));
    chk({tag, ".ovf"},     32'(ovf),     32'(m_ovf));
    chk({tag, ".unf"},     32'(unf),     32'(m_unf));
`ifdef STACK_WATERMARK_EN
    chk({tag, ".max"},     32'(max_count), 32'(m_max));
`endif
  endtask

  task automatic step(input string tag, input logic r, input logic it, input logic ps,
                      input logic pp, input logic [WIDTH-1:0] din, input logic cw);
    rst = r; init = it; push = ps; pop = pp; d_in = din;
`ifdef STACK_WATERMARK_EN
    clr_wm = cw;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0; init = 1'b0; push = 1'b0; pop = 1'b0;
`ifdef STACK_WATERMARK_EN
    clr_wm = 1'b0;
`endif
    m_dv = 0; m_ovf = 0; m_unf = 0;
    if (r || it) begin
      q.delete();
      m_dout = 0;
      m_max  = 0;
    end else begin
      if (pp) begin
        if (q.size() > 0) begin
          m_dout = q[$];
          m_dv   = 1;
          if (ps) q[q.size()-1] = int'(din);
          else    void'(q.pop_back());
        end else begin
          m_unf = 1;
          if (ps) q.push_back(int'(din));
        end
      end else if (ps) begin
        if (q.size() < DEPTH) q.push_back(int'(din));
        else                  m_ovf = 1;
      end
      if (cw)                 m_max = q.size();
      else if (q.size() > m_max) m_max = q.size();
    end
    check_all(tag);
  endtask

  initial begin
    @(negedge clk);
    step("reset", 1, 0, 0, 0, 2'd0, 0);

    // LIFO order
    step("t1.push1", 0, 0, 1, 0, 2'd1, 0);
    step("t1.push2", 0, 0, 1, 0, 2'd2, 0);
    step("t1.push3", 0, 0, 1, 0, 2'd3, 0);
    chk("t1.count3", 32'(count), 32'd3);
    chk("t1.top3",   32'(top),   32'd3);
    step("t1.pop_a", 0, 0, 0, 1, 2'd0, 0);
    chk("t1.dout3", 32'(d_out), 32'd3);
    step("t1.pop_b", 0, 0, 0, 1, 2'd0, 0);
    chk("t1.dout2", 32'(d_out), 32'd2);
    step("t1.pop_c", 0, 0, 0, 1, 2'd0, 0);
    chk("t1.dout1", 32'(d_out), 32'd1);
    chk("t1.empty", 32'(empty), 32'd1);

    // Fill then overflow
    step("t2.push_a", 0, 0, 1, 0, 2'd3, 0);
    step("t2.push_b", 0, 0, 1, 0, 2'd1, 0);
    step("t2.push_c", 0, 0, 1, 0, 2'd2, 0);
    step("t2.push_d", 0, 0, 1, 0, 2'd1, 0);
    chk("t2.full", 32'(full), 32'd1);
    step("t2.ovf", 0, 0, 1, 0, 2'd0, 0);
    chk("t2.ovf_pulse", 32'(ovf), 32'd1);
    chk("t2.top_kept",  32'(top), 32'd1);
    step("t2.idle", 0, 0, 0, 0, 2'd0, 0);

    // Drain then underflow
    for (int i = 0; i < 4; i++) step("t3.drain", 0, 0, 0, 1, 2'd0, 0);
    chk("t3.last_dout", 32'(d_out), 32'd3);
    step("t3.unf", 0, 0, 0, 1, 2'd0, 0);
    chk("t3.unf_pulse", 32'(unf),     32'd1);
    chk("t3.no_valid",  32'(d_valid), 32'd0);
    chk("t3.dout_held", 32'(d_out),   32'd3);

    // Replace top, including at full
    step("t4.push1", 0, 0, 1, 0, 2'd1, 0);
    step("t4.push2", 0, 0, 1, 0, 2'd2, 0);
    step("t4.repl",  0, 0, 1, 1, 2'd0, 0);
    chk("t4.dout2", 32'(d_out), 32'd2);
    chk("t4.top0",  32'(top),   32'd0);
    step("t4.push3", 0, 0, 1, 0, 2'd3, 0);
    step("t4.push4", 0, 0, 1, 0, 2'd1, 0);
    step("t4.repl_full", 0, 0, 1, 1, 2'd2, 0);
    chk("t4.no_ovf", 32'(ovf),   32'd0);
    chk("t4.count4", 32'(count), 32'd4);

    // init beats a simultaneous push
    step("t5.rst", 1, 0, 0, 0, 2'd0, 0);
    for (int i = 0; i < 3; i++) step("t5.push", 0, 0, 1, 0, 2'(i + 1), 0);
    step("t5.pop", 0, 0, 0, 1, 2'd0, 0);
    step("t5.push", 0, 0, 1, 0, 2'd2, 0);
    step("t5.init", 0, 1, 1, 0, 2'd1, 0);
    chk("t5.empty", 32'(empty), 32'd1);
    chk("t5.dout0", 32'(d_out), 32'd0);

    // push+pop on empty acts as a push with underflow flagged
    step("t5b.pp_empty", 0, 0, 1, 1, 2'd2, 0);
    chk("t5b.count1", 32'(count), 32'd1);
    chk("t5b.unf",    32'(unf),   32'd1);

    // High-water mark
    step("t6.init", 0, 1, 0, 0, 2'd0, 0);
    for (int i = 0; i < 3; i++) step("t6.push", 0, 0, 1, 0, 2'(i), 0);
    for (int i = 0; i < 2; i++) step("t6.pop", 0, 0, 0, 1, 2'd0, 0);
    step("t6.clr", 0, 0, 0, 0, 2'd0, 1);
`ifdef STACK_WATERMARK_EN
    chk("t6.max1", 32'(max_count), 32'd1);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic r, it, ps, pp, cw;
      r  = ($urandom_range(0, 149) == 0);
      it = ($urandom_range(0, 59) == 0);
      ps = ($urandom_range(0, 99) < 55);
      pp = ($urandom_range(0, 99) < 45);
      cw = ($urandom_range(0, 29) == 0);
      step("rand", r, it, ps, pp, 2'($urandom), cw);
    end
    step("rand.idle", 0, 0, 0, 0, 2'd0, 0);

    // Non-power-of-two depth
    p5_rst = 1'b1;
    @(posedge clk); #1;
    p5_rst = 1'b0;
    chk("d5.reset_empty", 32'(p5_empty), 32'd1);
    for (int i = 0; i < 5; i++) begin
      p5_push = 1'b1;
      p5_din  = 2'(i);
      @(posedge clk); #1;
      p5_push = 1'b0;
      chk("d5.count", 32'(p5_count), 32'(i + 1));
      chk("d5.full",  32'(p5_full),  32'(i == 4));
    end
    chk("d5.top", 32'(p5_top), 32'd0);
    p5_push = 1'b1;
    @(posedge clk); #1;
    p5_push = 1'b0;
    chk("d5.ovf",   32'(p5_ovf),   32'd1);
    chk("d5.count", 32'(p5_count), 32'd5);
    p5_pop = 1'b1;
    @(posedge clk); #1;
    p5_pop = 1'b0;
    chk("d5.pop_dout", 32'(p5_dout), 32'd0);
    chk("d5.pop_top",  32'(p5_top),  32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
